// File: rtl/fir_pkg.sv
// Shared types and width helpers for the moving-average FIR slice.
package fir_pkg;

  localparam int unsigned DATA_W_DEF = 8;

  typedef logic signed [DATA_W_DEF-1:0] sample_t;

  // Headroom covers the sum of `taps` full-scale samples, plus a sign bit.
  function automatic int unsigned sum_width(input int unsigned data_w, input int unsigned taps);
    return data_w + $clog2(taps) + 1;
  endfunction

endpackage

// File: rtl/fir_const_div.sv
// Signed divide of the window sum by the constant tap count, truncating toward zero.
module fir_const_div
  import fir_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned TAPS   = 3,
  parameter int unsigned SUM_W  = sum_width(DATA_W, TAPS)
) (
  input  logic signed [SUM_W-1:0]  i_sum,
  output logic signed [DATA_W-1:0] o_quot
);

  localparam logic signed [SUM_W-1:0] DIVISOR = SUM_W'(TAPS);

  // The quotient magnitude never exceeds one sample, so dropping the upper bits is lossless.
  assign o_quot = DATA_W'(i_sum / DIVISOR);

endmodule

// File: rtl/fir_moving_average.sv
// Streaming TAPS-point moving average: tap/sum stage followed by a divide/output stage.
module fir_moving_average
  import fir_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned TAPS   = 3,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                     CLOCK_50,
  input  logic                     RESET_N,
  input  logic                     enable,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]         sample_count
);

  localparam int unsigned SUM_W = sum_width(DATA_W, TAPS);

  logic                     r_en;
  logic                     w_start;
  logic                     w_s2_load;
  logic                     w_accept;

  logic signed [DATA_W-1:0] r_taps [TAPS];
  logic signed [SUM_W-1:0]  r_sum;
  logic signed [SUM_W-1:0]  w_sum_next;
  logic                     r_s1_valid;
  logic [CNT_W-1:0]         r_count;

  logic                     r_out_valid;
  logic signed [DATA_W-1:0] r_out_data;
  logic signed [DATA_W-1:0] w_quot;

  assign w_start   = enable & ~r_en;
  assign w_s2_load = ~r_out_valid | out_ready;
  assign in_ready  = enable & ~w_start & (~r_s1_valid | w_s2_load);
  assign w_accept  = in_valid & in_ready;

  // Running window sum: add the newcomer, retire the oldest tap.
  assign w_sum_next = r_sum + SUM_W'(in_data) - SUM_W'(r_taps[TAPS-1]);

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_en <= 1'b0;
    end else begin
      r_en <= enable;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int unsigned i = 0; i < TAPS; i++) begin
        r_taps[i] <= '0;
      end
      r_sum      <= '0;
      r_s1_valid <= 1'b0;
      r_count    <= '0;
    end else if (w_start) begin
      for (int unsigned i = 0; i < TAPS; i++) begin
        r_taps[i] <= '0;
      end
      r_sum      <= '0;
      r_s1_valid <= 1'b0;
      r_count    <= '0;
    end else if (w_accept) begin
      r_taps[0] <= in_data;
      for (int unsigned i = 1; i < TAPS; i++) begin
        r_taps[i] <= r_taps[i-1];
      end
      r_sum      <= w_sum_next;
      r_s1_valid <= 1'b1;
      r_count    <= r_count + CNT_W'(1);
    end else if (w_s2_load) begin
      r_s1_valid <= 1'b0;
    end
  end

  fir_const_div #(
    .DATA_W (DATA_W),
    .TAPS   (TAPS),
    .SUM_W  (SUM_W)
  ) u_div (
    .i_sum  (r_sum),
    .o_quot (w_quot)
  );

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_start) begin
      r_out_valid <= 1'b0;
    end else if (w_s2_load) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_data <= w_quot;
      end
    end
  end

  assign out_valid    = r_out_valid;
  assign out_data     = r_out_data;
  assign sample_count = r_count;

endmodule

// File: tb/tb_fir_moving_average.sv
// Directed and scoreboard bench for fir_moving_average at TAPS = 3, 4 and 7.
module tb_fir_moving_average;
  import fir_pkg::*;

  logic    clk = 1'b0;
  logic    rst_n = 1'b0;
  logic    enable = 1'b0;
  logic    in_valid = 1'b0;
  logic    out_ready = 1'b0;
  sample_t in_data = '0;

  logic        ir3, ov3, ir4, ov4, ir7, ov7;
  sample_t     od3, od4, od7;
  logic [15:0] sc3, sc4, sc7;

  always #5 clk = ~clk;

  fir_moving_average #(.DATA_W(8), .TAPS(3), .CNT_W(16)) u_dut3 (
    .CLOCK_50(clk), .RESET_N(rst_n), .enable(enable), .in_valid(in_valid), .in_ready(ir3),
    .in_data(in_data), .out_valid(ov3), .out_ready(out_ready), .out_data(od3),
    .sample_count(sc3)
  );
  fir_moving_average #(.DATA_W(8), .TAPS(4), .CNT_W(16)) u_dut4 (
    .CLOCK_50(clk), .RESET_N(rst_n), .enable(enable), .in_valid(in_valid), .in_ready(ir4),
    .in_data(in_data), .out_valid(ov4), .out_ready(out_ready), .out_data(od4),
    .sample_count(sc4)
  );
  fir_moving_average #(.DATA_W(8), .TAPS(7), .CNT_W(16)) u_dut7 (
    .CLOCK_50(clk), .RESET_N(rst_n), .enable(enable), .in_valid(in_valid), .in_ready(ir7),
    .in_data(in_data), .out_valid(ov7), .out_ready(out_ready), .out_data(od7),
    .sample_count(sc7)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input int obs, input int expv);
    n_checks++;
    if (obs != expv) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run();
    enable = 1'b0;
    tick();
    enable = 1'b1;
    check("start_cycle_ready", ir3, 0);
    tick();
  endtask

  int v_in [8];
  int v_exp [8];

  // Each sample is presented for one cycle; its average must show two edges later.
  task automatic stream(input string tag, input int n);
    out_ready = 1'b1;
    for (int i = 0; i <= n + 1; i++) begin
      if (i < n) begin
        in_valid = 1'b1;
        in_data  = sample_t'(v_in[i]);
        check({tag, "_ready"}, ir3, 1);
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (i == 0 || i == n + 1) begin
        check({tag, "_valid_low"}, ov3, 0);
      end else begin
        check({tag, "_valid"}, ov3, 1);
        check({tag, "_data"}, od3, v_exp[i-1]);
      end
    end
  endtask

  // Reference model: per-DUT sample history, window re-summed from scratch each accept.
  int h3 [7];
  int h4 [7];
  int h7 [7];
  int exp3 [$];
  int exp4 [$];
  int exp7 [$];
  int acc3, acc4, acc7;
  bit sb_on = 1'b0;

  function automatic int avg_win(input int h [7], input int t);
    int s = 0;
    for (int i = 0; i < t; i++) s += h[i];
    return s / t;
  endfunction

  always @(negedge clk) begin
    if (sb_on) begin
      if (ov3 && out_ready) check("rnd_avg3", od3, (exp3.size() != 0) ? exp3.pop_front() : 9999);
      if (ov4 && out_ready) check("rnd_avg4", od4, (exp4.size() != 0) ? exp4.pop_front() : 9999);
      if (ov7 && out_ready) check("rnd_avg7", od7, (exp7.size() != 0) ? exp7.pop_front() : 9999);
      if (in_valid && ir3) begin
        for (int i = 6; i > 0; i--) h3[i] = h3[i-1];
        h3[0] = in_data;
        exp3.push_back(avg_win(h3, 3));
        acc3++;
      end
      if (in_valid && ir4) begin
        for (int i = 6; i > 0; i--) h4[i] = h4[i-1];
        h4[0] = in_data;
        exp4.push_back(avg_win(h4, 4));
        acc4++;
      end
      if (in_valid && ir7) begin
        for (int i = 6; i > 0; i--) h7[i] = h7[i-1];
        h7[0] = in_data;
        exp7.push_back(avg_win(h7, 7));
        acc7++;
      end
    end
  end

  int bp_in [5];
  int idx;
  int cyc;

  initial begin
    // Power-on reset
    repeat (2) tick();
    check("rst_out_valid", ov3, 0);
    check("rst_out_data", od3, 0);
    check("rst_count", sc3, 0);
    check("rst_in_ready", ir3, 0);
    rst_n = 1'b1;
    tick();
    check("idle_in_ready", ir3, 0);

    // Basic averaging and latency
    start_run();
    v_in  = '{3, 6, 9, -3, 0, 0, 0, 0};
    v_exp = '{1, 3, 6, 4, 0, 0, 0, 0};
    stream("basic", 4);
    check("basic_count", sc3, 4);

    // Truncation toward zero and full-scale negative
    start_run();
    v_in  = '{-1, -1, 0, -128, -128, -128, 0, 0};
    v_exp = '{0, 0, 0, -43, -85, -128, 0, 0};
    stream("trunc", 6);
    check("trunc_count", sc3, 6);

    // Backpressure: taps hold -128 x3, so 10 -> -82 and 20 -> -32
    bp_in = '{10, 20, 30, 40, 50};
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_data  = sample_t'(bp_in[idx]);
      if (ir3) begin
        tick();
        idx++;
      end else begin
        tick();
      end
    end
    in_valid = 1'b0;
    check("bp_accepted", idx, 2);
    check("bp_in_ready", ir3, 0);
    check("bp_valid", ov3, 1);
    check("bp_held_data", od3, -82);
    out_ready = 1'b1;
    tick();
    check("bp_rel_valid", ov3, 1);
    check("bp_rel_data", od3, -32);
    tick();
    check("bp_rel_drained", ov3, 0);
    in_valid = 1'b1;
    in_data  = sample_t'(bp_in[idx]);
    check("bp_next_ready", ir3, 1);
    tick();
    in_valid = 1'b0;
    tick();
    check("bp_next_valid", ov3, 1);
    check("bp_next_data", od3, 20);
    check("bp_count", sc3, 9);

    // Stop and restart mid-stream
    enable   = 1'b0;
    in_valid = 1'b1;
    in_data  = sample_t'(99);
    tick();
    check("stop_ready", ir3, 0);
    tick();
    check("stop_count", sc3, 9);
    check("stop_drained", ov3, 0);
    enable = 1'b1;
    check("restart_ready", ir3, 0);
    tick();
    check("restart_count_clr", sc3, 0);
    check("restart_ready_up", ir3, 1);
    in_data = sample_t'(9);
    tick();
    in_valid = 1'b0;
    check("restart_count", sc3, 1);
    tick();
    check("restart_valid", ov3, 1);
    check("restart_data", od3, 3);

    // Asynchronous reset while output is valid
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = sample_t'(50);
    tick();
    in_valid = 1'b0;
    tick();
    check("pre_rst_valid", ov3, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", ov3, 0);
    check("async_rst_data", od3, 0);
    check("async_rst_count", sc3, 0);
    check("async_rst_ready", ir3, 0);
    enable = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // Random traffic on all three window lengths
    start_run();
    h3 = '{default: 0};
    h4 = '{default: 0};
    h7 = '{default: 0};
    acc3 = 0;
    acc4 = 0;
    acc7 = 0;
    sb_on = 1'b1;
    cyc = 0;
    while (acc3 < 10000 && cyc < 60000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = sample_t'($urandom_range(0, 255));
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (6) tick();
    sb_on = 1'b0;
    check("rnd_accepted3", acc3, 10000);
    check("rnd_accepted4", acc4, 10000);
    check("rnd_accepted7", acc7, 10000);
    check("rnd_left3", exp3.size(), 0);
    check("rnd_left4", exp4.size(), 0);
    check("rnd_left7", exp7.size(), 0);
    check("rnd_count3", sc3, acc3 % 65536);
    check("rnd_count4", sc4, acc4 % 65536);
    check("rnd_count7", sc7, acc7 % 65536);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
